// File: rtl/td4_runctl.sv
// TD4 run controller: HALT/RUN/STEP/LOAD sequencing, CPU clock-enable divider,
// program-write handshake and instruction counter. Breakpoints need TD4_RUNCTL_BP_EN.
module td4_runctl #(
    parameter int unsigned CLK_DIV = 3,
    parameter int unsigned ICNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic [3:0]        pc,
    input  logic              bp_en,
    input  logic [3:0]        bp_addr,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [7:0]        prog_data,
    output logic              prog_ack,
    output logic              mem_we,
    output logic [3:0]        mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              bp_hit,
    output logic [ICNT_W-1:0] icount
);

    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              first_q, first_d;
    logic              bp_hit_q, bp_hit_d;
    logic [ICNT_W-1:0] icount_q, icount_d;
    logic [3:0]        waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              ack_q, ack_d;
    logic              cpu_en_c;
    logic              bp_stop_c;

`ifdef TD4_RUNCTL_BP_EN
    // First tick after entering RUN is exempt so a resume from the breakpoint proceeds.
    assign bp_stop_c = bp_en && (pc == bp_addr) && !first_q;
    assign bp_hit    = bp_hit_q;
`else
    logic unused_bp;
    assign bp_stop_c = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, pc, first_q, bp_hit_q};
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_HALT;
            div_q    <= '0;
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
            icount_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            first_q  <= first_d;
            bp_hit_q <= bp_hit_d;
            icount_q <= icount_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            mem_we_q <= mem_we_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state logic; cpu_en is combinational so halt_req/breakpoint can veto the current tick.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        first_d  = first_q;
        bp_hit_d = bp_hit_q;
        icount_d = icount_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        mem_we_d = 1'b0;
        ack_d    = 1'b0;
        cpu_en_c = 1'b0;

        case (state_q)
            ST_HALT: begin
                if (prog_we) begin
                    state_d  = ST_LOAD;
                    waddr_d  = prog_addr;
                    wdata_d  = prog_data;
                    mem_we_d = 1'b1;
                    ack_d    = 1'b1;
                    icount_d = '0;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    bp_hit_d = 1'b0;
                end else if (run_req) begin
                    state_d  = ST_RUN;
                    div_d    = '0;
                    first_d  = 1'b1;
                    bp_hit_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_HALT;
            end
            ST_STEP: begin
                cpu_en_c = 1'b1;
                state_d  = ST_HALT;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    div_d   = '0;
                end else if (div_q == DIV_MAX) begin
                    div_d   = '0;
                    first_d = 1'b0;
                    if (bp_stop_c) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end else begin
                        cpu_en_c = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (cpu_en_c) begin
            icount_d = icount_q + ICNT_W'(1);
        end
    end

    assign cpu_en    = cpu_en_c;
    assign state     = state_q;
    assign icount    = icount_q;
    assign mem_we    = mem_we_q;
    assign prog_ack  = ack_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_td4_runctl.sv
// Scoreboard bench for td4_runctl: per-cycle expected observations are queued with stimulus.
module tb_td4_runctl;

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       we;
        logic       ack;
        logic       bp;
        logic [7:0] ic;
        logic [3:0] wa;
        logic [7:0] wd;
    } obs_t;

    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] S_RUN  = 4'b0001;
    localparam logic [3:0] S_STEP = 4'b0010;
    localparam logic [3:0] S_HALT = 4'b0100;
    localparam logic [3:0] S_PROG = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_req, step_req, halt_req;
    logic [3:0] pc;
    logic       bp_en;
    logic [3:0] bp_addr;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_ack, mem_we, cpu_en, bp_hit;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [1:0] state;
    logic [7:0] icount;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic cpu_seen;
    obs_t exp_q[$];
    logic [3:0] stim_q[$];

    always #5 clk = ~clk;

    td4_runctl #(.CLK_DIV(3), .ICNT_W(8)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ack(prog_ack), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_en(cpu_en), .state(state),
        .bp_hit(bp_hit), .icount(icount)
    );

    function automatic obs_t mk(input logic [1:0] st, input logic en, input logic we,
                                input logic ack, input logic bp, input logic [7:0] ic,
                                input logic [3:0] wa = 4'h0, input logic [7:0] wd = 8'h00);
        obs_t o;
        o.st = st; o.en = en; o.we = we; o.ack = ack; o.bp = bp;
        o.ic = ic; o.wa = wa; o.wd = wd;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(state, cpu_en, mem_we, prog_ack, bp_hit, icount, mem_waddr, mem_wdata);
    endfunction

    // One cycle: inputs applied mid-cycle, the bench CPU advances pc on each executed instruction.
    task automatic drive(input logic [3:0] s);
        @(negedge clk);
        pc       = pc + 4'(cpu_seen);
        run_req  = s[0];
        step_req = s[1];
        halt_req = s[2];
        prog_we  = s[3];
        #1;
        cpu_seen = cpu_en;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; prog_we = 1'b0;
        pc = 4'h0; bp_en = 1'b0; bp_addr = 4'h0; prog_addr = 4'h0; prog_data = 8'h00;
        cpu_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        reset = 1'b0;
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; prog_we = 1'b0;
        pc = 4'h0; bp_en = 1'b0; bp_addr = 4'h0; prog_addr = 4'h0; prog_data = 8'h00;
        cpu_seen = 1'b0;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        #3;
        got = observe();
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_values got %h exp %h", got, exp);
        end
    endtask

    task automatic test_run();
        obs_t got, exp;
        do_reset();
        stim_q.push_back(S_RUN); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        for (int k = 1; k <= 13; k++) begin
            stim_q.push_back(k == 2 ? S_STEP : (k == 6 ? S_RUN : S_IDLE));
            exp_q.push_back(mk(2'd1, (k % 4) == 0, 1'b0, 1'b0, 1'b0, 8'((k - 1) / 4)));
        end
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL run cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_halt_on_tick();
        obs_t got, exp;
        do_reset();
        stim_q.push_back(S_RUN); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        for (int k = 1; k <= 3; k++) begin
            stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        end
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_RUN);  exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        for (int k = 7; k <= 10; k++) begin
            stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd1, k == 10, 1'b0, 1'b0, 1'b0, 8'd0));
        end
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL halt_on_tick cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_step();
        obs_t got, exp;
        do_reset();
        bp_en = 1'b1;
        bp_addr = 4'h0;
        stim_q.push_back(S_STEP); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_RUN | S_STEP); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
        for (int i = 0; i < 254; i++) begin
            stim_q.push_back(S_STEP); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(2 + i)));
            stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'(2 + i)));
        end
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL step cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_load();
        obs_t got, exp;
        do_reset();
        prog_addr = 4'd5;
        prog_data = 8'hB3;
        stim_q.push_back(S_STEP); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        stim_q.push_back(S_PROG | S_STEP); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_PROG); exp_q.push_back(mk(2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd5, 8'hB3));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd5, 8'hB3));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_prog_in_run();
        obs_t got, exp;
        do_reset();
        prog_addr = 4'd9;
        prog_data = 8'h5C;
        stim_q.push_back(S_RUN); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        for (int k = 1; k <= 5; k++) begin
            stim_q.push_back(S_PROG);
            exp_q.push_back(mk(2'd1, k == 4, 1'b0, 1'b0, 1'b0, k > 4 ? 8'd1 : 8'd0));
        end
        stim_q.push_back(S_PROG | S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_PROG); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_PROG); exp_q.push_back(mk(2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd9, 8'h5C));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd9, 8'h5C));
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL prog_in_run cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_breakpoint();
        obs_t got, exp;
        do_reset();
        pc = 4'd5;
        bp_en = 1'b1;
        bp_addr = 4'd6;
        stim_q.push_back(S_RUN); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
`ifdef TD4_RUNCTL_BP_EN
        for (int k = 1; k <= 7; k++) begin
            stim_q.push_back(S_IDLE);
            exp_q.push_back(mk(2'd1, k == 4, 1'b0, 1'b0, 1'b0, k > 4 ? 8'd1 : 8'd0));
        end
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        stim_q.push_back(S_RUN);  exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
        for (int k = 10; k <= 17; k++) begin
            stim_q.push_back(S_IDLE);
            exp_q.push_back(mk(2'd1, k == 13 || k == 17, 1'b0, 1'b0, 1'b0, k > 13 ? 8'd2 : 8'd1));
        end
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
`else
        for (int k = 1; k <= 9; k++) begin
            stim_q.push_back(S_IDLE);
            exp_q.push_back(mk(2'd1, k == 4 || k == 8, 1'b0, 1'b0, 1'b0,
                               k > 8 ? 8'd2 : (k > 4 ? 8'd1 : 8'd0)));
        end
        stim_q.push_back(S_HALT); exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
        stim_q.push_back(S_IDLE); exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
`endif
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL breakpoint cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_in_load();
        obs_t got, exp;
        do_reset();
        prog_addr = 4'hA;
        prog_data = 8'h7E;
        drive(S_PROG);
        drive(S_PROG);
        exp_q.push_back(mk(2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'hA, 8'h7E));
        got = observe();
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_in_load pre got %h exp %h", got, exp);
        end
        #2;
        reset = 1'b0;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        #1;
        got = observe();
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_in_load async got %h exp %h", got, exp);
        end
        prog_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
            drive(S_IDLE);
            got = observe();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_in_load post cyc%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt_on_tick();
        test_step();
        test_load();
        test_prog_in_run();
        test_breakpoint();
        test_reset_in_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
